coin_acceptor: RTL and testbench
================================

// Module: coin_acceptor
// PURPOSE
//  Front-end coin mechanism interface that drives the vending FSM's coin_in bus.
//  Synchronises and debounces the raw optical coin sensor, then measures how long
//  the coin blocks the beam to classify it as a 1-rupee or 2-rupee coin.
//  Emits a one-cycle coin code; rejects bad, jammed or unwanted coins.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive equal synced samples before sensor_db changes
//  ONE_MIN          8   min beam-blocked cycles for a 1-rupee coin
//  ONE_MAX          15  max beam-blocked cycles for a 1-rupee coin
//  TWO_MIN          16  min beam-blocked cycles for a 2-rupee coin
//  TWO_MAX          31  max beam-blocked cycles for a 2-rupee coin
//  CNT_W            6   width counter bits; saturation value SAT = 2^CNT_W-1 (63)
//  GAP_CYCLES       4   sensor_db low cycles required before next coin is accepted
//  Legal only if ONE_MIN<=ONE_MAX<TWO_MIN<=TWO_MAX<SAT.
// PORTS
//  clock      in   1  system clock
//  reset      in   1  asynchronous, active-high
//  sensor_in  in   1  raw beam sensor, asynchronous, 1 = coin in beam
//  accept_en  in   1  vending FSM can take a coin; 0 = reject every coin
//  coin_in    out  2  00 none, 10 one rupee, 11 two rupee; 01 never driven
//  reject     out  1  one-cycle pulse: coin diverted to return chute
//  busy       out  1  1 when not in IDLE
// BEHAVIOUR
//  Reset: reset is asynchronous, active-high; clock is clock. Reset state is GAP.
//   Reset values: coin_in=00, reject=0, busy=1, sync flops 0, counters 0.
//   A coin already in the beam at reset release is ignored. It is not classified.
//  Input path: 2-flop synchroniser, then debounce. sensor_db toggles when
//   DEBOUNCE_CYCLES consecutive synced samples differ from it. Pulses shorter
//   than that are invisible.
//  FSM (states IDLE, MEASURE, EMIT, JAM, GAP):
//   IDLE:    busy=0. A sensor_db rise moves to MEASURE with width=1.
//   MEASURE: width+1 per cycle while sensor_db=1.
//            On sensor_db fall, go to EMIT.
//            If width reaches SAT, go to JAM and pulse reject once.
//   EMIT:    one cycle. Decode width and accept_en sampled this cycle:
//            accept_en=0 -> reject=1.
//            Else ONE_MIN..ONE_MAX -> coin_in=10.
//            Else TWO_MIN..TWO_MAX -> coin_in=11.
//            Else reject=1.
//            Next state is GAP.
//   JAM:     wait for sensor_db=0, then GAP. No coin code is emitted.
//   GAP:     count consecutive sensor_db=0 cycles; after GAP_CYCLES go to IDLE.
//            A sensor_db rise in GAP goes to JAM with a reject pulse.
//  Outputs are registered. coin_in and reject are mutually exclusive.
//  Each is high for exactly 1 cycle per coin, and coin_in is 00 otherwise.
//  Latency: coin_in/reject assert DEBOUNCE_CYCLES+3 clocks after the raw sensor_in fall.
//  Measured width equals the raw pulse width. Debounce delay is symmetric.
//  Width counter saturates and never wraps.
//  accept_en is sampled only in EMIT. Changes during MEASURE have no effect.
//  Reset mid-coin: outputs drop to reset values immediately. The partial coin is
//   discarded, with no coin and no reject.
// STRUCTURE
//  vending_pkg holds:
//   coin codes COIN_NONE=2'b00, COIN_ONE=2'b10, COIN_TWO=2'b11;
//   acceptor state encodings, shared with vending_machine_fsm.
//  One sub-module, sensor_debounce: synchroniser + debounce counter,
//   parameter DEBOUNCE_CYCLES, output sensor_db.
//  Top level: FSM, width counter, gap counter, output registers.
// TESTING
//  1 accept_en=1, 10-cycle sensor pulse -> coin_in=10 for 1 cycle, 7 clks after fall.
//  2 accept_en=1, 20-cycle pulse -> coin_in=11 for 1 cycle; reject stays 0.
//  3 5-cycle pulse, then 40-cycle pulse -> reject pulse each; coin_in stays 00.
//  4 2-cycle glitch -> no output, busy stays 0.
//    Next, 10-cycle pulse with accept_en=0 -> reject pulse only.
//  5 sensor held high 80 cycles -> one reject at width 63, no coin.
//    After sensor falls: busy high for GAP_CYCLES, then IDLE.
//  6 reset mid-MEASURE with sensor high -> coin_in=00, reject=0, busy=1.
//    No output for that coin; IDLE once sensor is low for GAP_CYCLES.
//    Next, 10-cycle pulse -> coin_in=10.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared vending types: coin codes on the coin_in bus, acceptor state encodings,
// and the width-to-coin decode used when a coin has left the beam.
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_ONE  = 2'b10;
    localparam logic [1:0] COIN_TWO  = 2'b11;

    typedef enum logic [2:0] {
        ACC_IDLE    = 3'd0,
        ACC_MEASURE = 3'd1,
        ACC_EMIT    = 3'd2,
        ACC_JAM     = 3'd3,
        ACC_GAP     = 3'd4
    } acc_state_t;

    typedef struct packed {
        logic [1:0] coin;
        logic       reject;
    } acc_out_t;

    // Widths outside both coin windows, or any coin the vending FSM cannot take, are rejected.
    function automatic acc_out_t decode_width(
        input int unsigned width,
        input logic        accept,
        input int unsigned one_min,
        input int unsigned one_max,
        input int unsigned two_min,
        input int unsigned two_max
    );
        acc_out_t o;
        o.coin   = COIN_NONE;
        o.reject = 1'b0;
        if (!accept)
            o.reject = 1'b1;
        else if (width >= one_min && width <= one_max)
            o.coin = COIN_ONE;
        else if (width >= two_min && width <= two_max)
            o.coin = COIN_TWO;
        else
            o.reject = 1'b1;
        return o;
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensor and accept enable in, coin code / reject / busy out.
interface coin_acceptor_if;
    logic       sensor_in;
    logic       accept_en;
    logic [1:0] coin_in;
    logic       reject;
    logic       busy;

    modport master (output sensor_in, output accept_en,
                    input  coin_in, input reject, input busy);
    modport slave  (input  sensor_in, input accept_en,
                    output coin_in, output reject, output busy);
endinterface

// File: rtl/coin_acceptor_debounce.sv
// Two-flop synchroniser followed by a debounce counter: sensor_db only follows the
// synced sensor after DEBOUNCE_CYCLES consecutive differing samples.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic sensor_in,
    output logic sensor_sync,
    output logic sensor_db
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1       <= 1'b0;
            sensor_sync <= 1'b0;
        end else begin
            sync1       <= sensor_in;
            sensor_sync <= sync1;
        end
    end

    // Rise and fall use the same count, so the debounced pulse keeps the raw width.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sensor_db <= 1'b0;
            db_cnt    <= '0;
        end else if (sensor_sync != sensor_db) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                sensor_db <= sensor_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: measures how long a coin blocks the debounced beam and emits a
// one-cycle coin code or reject pulse; jams and back-to-back coins are rejected.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned ONE_MIN         = 8,
    parameter int unsigned ONE_MAX         = 15,
    parameter int unsigned TWO_MIN         = 16,
    parameter int unsigned TWO_MAX         = 31,
    parameter int unsigned CNT_W           = 6,
    parameter int unsigned GAP_CYCLES      = 4
) (
    input  logic          clock,
    input  logic          reset,
    coin_acceptor_if.slave bus
);
    localparam logic [CNT_W-1:0] SAT      = '1;
    localparam int unsigned      GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic             sensor_sync, sensor_db;
    acc_state_t       state, state_nxt;
    logic [CNT_W-1:0] width, width_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic             fresh, fresh_nxt;
    logic [1:0]       coin_q, coin_nxt;
    logic             reject_q, reject_nxt;
    logic             busy_q;
    acc_out_t         dec;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .sensor_in  (bus.sensor_in),
        .sensor_sync(sensor_sync),
        .sensor_db  (sensor_db)
    );

    assign dec = decode_width(32'(width), bus.accept_en, ONE_MIN, ONE_MAX, TWO_MIN, TWO_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ACC_GAP;
            width    <= '0;
            gap_cnt  <= '0;
            fresh    <= 1'b1;
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state    <= state_nxt;
            width    <= width_nxt;
            gap_cnt  <= gap_nxt;
            fresh    <= fresh_nxt;
            coin_q   <= coin_nxt;
            reject_q <= reject_nxt;
            busy_q   <= (state_nxt != ACC_IDLE);
        end
    end

    always_comb begin
        state_nxt  = state;
        width_nxt  = width;
        gap_nxt    = gap_cnt;
        fresh_nxt  = fresh;
        coin_nxt   = COIN_NONE;
        reject_nxt = 1'b0;
        case (state)
            ACC_IDLE: begin
                if (sensor_db) begin
                    state_nxt = ACC_MEASURE;
                    width_nxt = CNT_W'(1);
                end
            end
            ACC_MEASURE: begin
                if (!sensor_db) begin
                    state_nxt = ACC_EMIT;
                end else if (width >= SAT - CNT_W'(1)) begin
                    width_nxt  = SAT;
                    state_nxt  = ACC_JAM;
                    reject_nxt = 1'b1;
                end else begin
                    width_nxt = width + CNT_W'(1);
                end
            end
            ACC_EMIT: begin
                coin_nxt   = dec.coin;
                reject_nxt = dec.reject;
                state_nxt  = ACC_GAP;
                gap_nxt    = '0;
            end
            ACC_JAM: begin
                if (!sensor_db) begin
                    state_nxt = ACC_GAP;
                    gap_nxt   = '0;
                end
            end
            ACC_GAP: begin
                // A coin still in the debounce pipe (synced high, debounced low) holds
                // off IDLE; one left over from reset is swallowed without a reject.
                if (sensor_db) begin
                    state_nxt  = ACC_JAM;
                    reject_nxt = !fresh;
                end else if (!sensor_sync) begin
                    if (gap_cnt == GAP_LAST) begin
                        state_nxt = ACC_IDLE;
                        fresh_nxt = 1'b0;
                    end else begin
                        gap_nxt = gap_cnt + GAP_W'(1);
                    end
                end else begin
                    gap_nxt = '0;
                end
            end
            default: state_nxt = ACC_GAP;
        endcase
    end

    assign bus.coin_in = coin_q;
    assign bus.reject  = reject_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed and random coin pulses compared
// against an outcome/timing model derived from the coin classification rules.
module tb_coin_acceptor;
    localparam int DEB     = 4;
    localparam int ONE_MIN = 8;
    localparam int ONE_MAX = 15;
    localparam int TWO_MIN = 16;
    localparam int TWO_MAX = 31;
    localparam int SAT     = 63;
    localparam int GAPC    = 4;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    coin_acceptor_if bus();

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DEB), .ONE_MIN(ONE_MIN), .ONE_MAX(ONE_MAX),
        .TWO_MIN(TWO_MIN), .TWO_MAX(TWO_MAX), .CNT_W(6), .GAP_CYCLES(GAPC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One coin of w raw cycles; accept_en wanders while the coin is in the beam and
    // settles to acc when it leaves.
    task automatic run_coin(input int w, input bit acc, input string tag);
        int c0, first_ev, n_coin, n_rej, code, bad, busy_seen;
        int exp_code, exp_rej, exp_cyc, exp_busy;
        first_ev = -1; n_coin = 0; n_rej = 0; code = 0; bad = 0; busy_seen = 0;
        @(negedge clock);
        c0 = cyc;
        for (int i = 0; i < w + 40; i++) begin
            bus.sensor_in = (i < w);
            bus.accept_en = (i < w) ? 1'($urandom_range(0, 1)) : acc;
            @(negedge clock);
            if (bus.busy) busy_seen = 1;
            if (bus.coin_in != 2'b00) begin
                n_coin++;
                code = int'(bus.coin_in);
                if (first_ev < 0) first_ev = cyc;
            end
            if (bus.reject) begin
                n_rej++;
                if (first_ev < 0) first_ev = cyc;
            end
            if (bus.coin_in == 2'b01 || (bus.coin_in != 2'b00 && bus.reject)) bad++;
        end

        // Reference: raw high is first sampled at edge c0+1 and first low at c0+w+1.
        exp_code = 0; exp_rej = 0; exp_cyc = -1; exp_busy = (w >= DEB) ? 1 : 0;
        if (w < DEB) begin
            exp_cyc = -1;
        end else if (w >= SAT) begin
            exp_rej = 1;
            exp_cyc = c0 + 1 + DEB + 1 + SAT;
        end else begin
            exp_cyc = c0 + w + 1 + DEB + 3;
            if (!acc)                              exp_rej  = 1;
            else if (w >= ONE_MIN && w <= ONE_MAX) exp_code = 2;
            else if (w >= TWO_MIN && w <= TWO_MAX) exp_code = 3;
            else                                   exp_rej  = 1;
        end

        check({tag, "_code"},     code, exp_code);
        check({tag, "_ncoin"},    n_coin, (exp_code != 0) ? 1 : 0);
        check({tag, "_nreject"},  n_rej, exp_rej);
        check({tag, "_latency"},  first_ev, exp_cyc);
        check({tag, "_exclusive"}, bad, 0);
        check({tag, "_busy_seen"}, busy_seen, exp_busy);
        check({tag, "_idle_end"}, int'(bus.busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_c, n_r;
        int bnd[10];
        bnd = '{3, 4, 7, 8, 15, 16, 31, 32, 62, 63};

        bus.sensor_in = 1'b0;
        bus.accept_en = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_coin",   int'(bus.coin_in), 0);
        check("rst_reject", int'(bus.reject), 0);
        check("rst_busy",   int'(bus.busy), 1);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("rst_idle", int'(bus.busy), 0);

        run_coin(10, 1'b1, "t1_one");
        run_coin(20, 1'b1, "t2_two");
        run_coin(5,  1'b1, "t3_short");
        run_coin(40, 1'b1, "t3_long");
        run_coin(2,  1'b1, "t4_glitch");
        run_coin(10, 1'b0, "t4_noaccept");
        run_coin(80, 1'b1, "t5_jam");

        // Reset while a coin is being measured; that coin must vanish silently.
        @(negedge clock);
        bus.sensor_in = 1'b1;
        repeat (15) @(negedge clock);
        reset = 1'b1;
        #1;
        check("t6_rst_coin",   int'(bus.coin_in), 0);
        check("t6_rst_reject", int'(bus.reject), 0);
        check("t6_rst_busy",   int'(bus.busy), 1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n_c = 0; n_r = 0;
        for (int i = 0; i < 60; i++) begin
            bus.sensor_in = (i < 20);
            @(negedge clock);
            if (bus.coin_in != 2'b00) n_c++;
            if (bus.reject) n_r++;
        end
        check("t6_no_coin",   n_c, 0);
        check("t6_no_reject", n_r, 0);
        check("t6_idle",      int'(bus.busy), 0);
        run_coin(10, 1'b1, "t6_after");

        foreach (bnd[i]) run_coin(bnd[i], 1'b1, "bnd");

        for (int i = 0; i < 25; i++)
            run_coin(int'($urandom_range(1, 70)), 1'($urandom_range(0, 1)), "rnd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
